// File: rtl/host_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : host_mem_pkg
// Description : Shared types and constants for the host memory responder.
//               Holds the responder state encoding, the cache-line width,
//               the default MMIO offset of the buffer base register and a
//               generic host-request record used by consumers of the host
//               channel (addresses/tags sized to the widest supported
//               configuration, narrower users zero-extend).
// Revision    : 1.0 - initial release
// ============================================================================
package host_mem_pkg;

    // Cache-line payload width in bits
    localparam int CL_W = 512;

    // Widest host address / tag carried by the generic request record
    localparam int HREQ_ADDR_W = 64;
    localparam int HREQ_TAG_W  = 32;

    // Default MMIO offset of the buffer base register
    localparam logic [15:0] BASE_MMIO_OFS_DFLT = 16'h0020;

    // Responder FSM states
    typedef enum logic [2:0] {
        ST_NO_BUF   = 3'd0,
        ST_READY    = 3'd1,
        ST_RD_ISSUE = 3'd2,
        ST_RD_WAIT  = 3'd3,
        ST_WR_ISSUE = 3'd4,
        ST_WR_WAIT  = 3'd5
    } state_e;

    // One host-channel request
    typedef struct packed {
        logic                   valid;
        logic [HREQ_ADDR_W-1:0] addr;
        logic [HREQ_TAG_W-1:0]  tag;
        logic [CL_W-1:0]        data;
    } host_req_t;

endpackage : host_mem_pkg
`default_nettype wire

// File: rtl/host_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : host_mem_responder
// Description : Responder end of the control unit's memory interface.
//               Accepts single-cache-line read/write requests addressed as a
//               line index relative to a buffer base (programmed via MMIO),
//               issues the matching host-channel request and reports
//               completion (data_valid + read_data, or write_done).
//               Exactly one transaction is in flight at a time; requests
//               that cannot be accepted are dropped and flagged in the
//               sticky proto_err output.
//
// Ports       :
//   clk, rst_n                  clock, asynchronous active-low reset
//   mmio_wr_*                   MMIO write port (base register at
//                               BASE_MMIO_OFS, line address in low bits)
//   buffer_addr_valid           base register is programmed and non-zero
//   address                     requested line index (offset from base)
//   read/write_request_valid    single-cycle request strobes
//   write_data                  write payload, sampled with the strobe
//   data_valid, read_data       read completion pulse and held payload
//   write_done                  write completion pulse
//   proto_err                   sticky flag: a request was dropped
//   host_rd_req_*, host_rd_*    host read request/response channel
//   host_wr_req_*, host_wr_*    host write request/ack channel
//
// Revision    : 1.0 - initial release
// ============================================================================
module host_mem_responder
    import host_mem_pkg::*;
#(
    parameter int          HADDR_W       = 42,
    parameter int          TAG_W         = 16,
    parameter logic [15:0] BASE_MMIO_OFS = BASE_MMIO_OFS_DFLT
) (
    input  logic               clk,
    input  logic               rst_n,

    // MMIO base register programming
    input  logic               mmio_wr_valid,
    input  logic [15:0]        mmio_wr_addr,
    input  logic [63:0]        mmio_wr_data,
    output logic               buffer_addr_valid,

    // Control-unit request / completion interface
    input  logic [31:0]        address,
    input  logic               read_request_valid,
    input  logic               write_request_valid,
    input  logic [CL_W-1:0]    write_data,
    output logic               data_valid,
    output logic [CL_W-1:0]    read_data,
    output logic               write_done,
    output logic               proto_err,

    // Host read channel
    output logic               host_rd_req_valid,
    output logic [HADDR_W-1:0] host_rd_req_addr,
    output logic [TAG_W-1:0]   host_rd_req_tag,
    input  logic               host_rd_almost_full,
    input  logic               host_rd_rsp_valid,
    input  logic [TAG_W-1:0]   host_rd_rsp_tag,
    input  logic [CL_W-1:0]    host_rd_rsp_data,

    // Host write channel
    output logic               host_wr_req_valid,
    output logic [HADDR_W-1:0] host_wr_req_addr,
    output logic [TAG_W-1:0]   host_wr_req_tag,
    output logic [CL_W-1:0]    host_wr_req_data,
    input  logic               host_wr_almost_full,
    input  logic               host_wr_rsp_valid,
    input  logic [TAG_W-1:0]   host_wr_rsp_tag
);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_e             r_state;
    logic [HADDR_W-1:0] r_base;
    logic               r_base_valid;
    logic [HADDR_W-1:0] r_addr_q;
    logic [CL_W-1:0]    r_data_q;
    logic [TAG_W-1:0]   r_tag_cnt;
    logic [TAG_W-1:0]   r_issued_tag;
    logic               r_data_valid;
    logic [CL_W-1:0]    r_read_data;
    logic               r_write_done;
    logic               r_proto_err;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic               w_base_wr;
    logic               w_any_req;
    logic               w_accept;
    logic               w_drop;
    logic [HADDR_W-1:0] w_line_addr;
    logic               w_rd_fire;
    logic               w_wr_fire;
    logic               w_rd_match;
    logic               w_wr_match;

    assign w_base_wr = mmio_wr_valid && (mmio_wr_addr == BASE_MMIO_OFS);
    assign w_any_req = read_request_valid || write_request_valid;

    // A request is taken only in READY with a live base; otherwise it is lost.
    assign w_accept  = (r_state == ST_READY) && r_base_valid;

    // Dropped: no acceptor, or a simultaneous read+write (the write loses).
    assign w_drop    = (w_any_req && !w_accept) ||
                       (w_accept && read_request_valid && write_request_valid);

    // Line index is zero-extended and added modulo 2^HADDR_W; overflow wraps.
    assign w_line_addr = r_base + HADDR_W'(address);

    // Host requests go out combinationally from the ISSUE state so that the
    // earliest host request lands the cycle right after the client request.
    assign w_rd_fire = (r_state == ST_RD_ISSUE) && !host_rd_almost_full;
    assign w_wr_fire = (r_state == ST_WR_ISSUE) && !host_wr_almost_full;

    // Only the response carrying the tag we issued completes the transaction.
    assign w_rd_match = (r_state == ST_RD_WAIT) && host_rd_rsp_valid &&
                        (host_rd_rsp_tag == r_issued_tag);
    assign w_wr_match = (r_state == ST_WR_WAIT) && host_wr_rsp_valid &&
                        (host_wr_rsp_tag == r_issued_tag);

    // ------------------------------------------------------------------
    // Buffer base register
    // ------------------------------------------------------------------
    // The validity flag is computed from the incoming value so it tracks the
    // base register with no extra cycle of lag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_base       <= '0;
            r_base_valid <= 1'b0;
        end else if (w_base_wr) begin
            r_base       <= mmio_wr_data[HADDR_W-1:0];
            r_base_valid <= |mmio_wr_data[HADDR_W-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Sticky protocol error
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_proto_err <= 1'b0;
        end else if (w_drop) begin
            r_proto_err <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Transaction FSM (shared by read and write paths)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_NO_BUF;
            r_addr_q     <= '0;
            r_data_q     <= '0;
            r_tag_cnt    <= '0;
            r_issued_tag <= '0;
            r_data_valid <= 1'b0;
            r_read_data  <= '0;
            r_write_done <= 1'b0;
        end else begin
            // Completion strobes are single-cycle pulses
            r_data_valid <= 1'b0;
            r_write_done <= 1'b0;

            case (r_state)
                ST_NO_BUF: begin
                    if (r_base_valid) begin
                        r_state <= ST_READY;
                    end
                end

                ST_READY: begin
                    if (!r_base_valid) begin
                        r_state <= ST_NO_BUF;
                    end else if (read_request_valid) begin
                        // Address is latched now, so a later base rewrite
                        // cannot disturb this transaction.
                        r_addr_q <= w_line_addr;
                        r_state  <= ST_RD_ISSUE;
                    end else if (write_request_valid) begin
                        r_addr_q <= w_line_addr;
                        r_data_q <= write_data;
                        r_state  <= ST_WR_ISSUE;
                    end
                end

                ST_RD_ISSUE: begin
                    if (w_rd_fire) begin
                        r_issued_tag <= r_tag_cnt;
                        r_tag_cnt    <= r_tag_cnt + TAG_W'(1);
                        r_state      <= ST_RD_WAIT;
                    end
                end

                ST_RD_WAIT: begin
                    if (w_rd_match) begin
                        r_read_data  <= host_rd_rsp_data;
                        r_data_valid <= 1'b1;
                        r_state      <= ST_READY;
                    end
                end

                ST_WR_ISSUE: begin
                    if (w_wr_fire) begin
                        r_issued_tag <= r_tag_cnt;
                        r_tag_cnt    <= r_tag_cnt + TAG_W'(1);
                        r_state      <= ST_WR_WAIT;
                    end
                end

                ST_WR_WAIT: begin
                    if (w_wr_match) begin
                        r_write_done <= 1'b1;
                        r_state      <= ST_READY;
                    end
                end

                default: begin
                    r_state <= ST_NO_BUF;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign buffer_addr_valid = r_base_valid;
    assign data_valid        = r_data_valid;
    assign read_data         = r_read_data;
    assign write_done        = r_write_done;
    assign proto_err         = r_proto_err;

    // The tag presented during ISSUE is the live counter value; it is
    // captured into r_issued_tag on the cycle the request is accepted.
    assign host_rd_req_valid = w_rd_fire;
    assign host_rd_req_addr  = r_addr_q;
    assign host_rd_req_tag   = r_tag_cnt;

    assign host_wr_req_valid = w_wr_fire;
    assign host_wr_req_addr  = r_addr_q;
    assign host_wr_req_tag   = r_tag_cnt;
    assign host_wr_req_data  = r_data_q;

endmodule : host_mem_responder
`default_nettype wire
